sincos_arbiter: RTL and testbench

- Shares one quarter-wave sine lookup table between two requesters. Typical requesters are the Park and inverse-Park stages of the FOC core.
- Each request carries an electrical angle. The block sequences two table reads, sin then cos, and applies quadrant folding and sign correction.
- It returns a signed sin/cos pair to the winning requester.
- Round-robin arbitration; one operation in flight at a time.

---
 rtl/sincos_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_sincos_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sincos_arbiter.sv
// -----------------------------------------------------------------------------
// sincos_arbiter
//
// Shares one quarter-wave sine lookup table between two requesters (for
// example the Park and inverse-Park stages of a FOC core). Each request
// carries an electrical angle. The block performs two table reads, sin then
// cos. It folds the angle into the first quadrant, fixes up the signs, and
// returns a signed sin/cos pair to the port that won arbitration.
// Arbitration is round-robin, and only one operation is in flight at a time.
//
// Angle format: angle[A-1:A-2] is the quadrant, angle[A-3:0] is the table
// index. The table holds sin((i+0.5)*pi/2^(A-1)) as an unsigned magnitude
// of N-1 bits. It has a one-cycle registered read.
//
// Optional build macro: SINCOS_CACHE_EN
//   When defined, the last completed angle is remembered. A grant for the
//   same angle is answered one cycle later from the held rsp_sin/rsp_cos
//   without touching the table.
//
// Parameters:
//   N  output sample width (signed); table magnitude width is N-1
//   A  angle width (2 quadrant bits + A-2 index bits)
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   req_valid   per-port request valid (bit p = port p)
//   req_angle0  port 0 angle
//   req_angle1  port 1 angle
//   req_ready   per-port accept, combinational in IDLE
//   tab_en      table read strobe
//   tab_addr    table read address
//   tab_data    table read data, valid the cycle after tab_en
//   rsp_valid   one-hot, single-cycle response strobe to the owning port
//   rsp_sin     signed sine result (held until the next response)
//   rsp_cos     signed cosine result (held until the next response)
// -----------------------------------------------------------------------------
module sincos_arbiter #(
  parameter int N = 16,
  parameter int A = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [A-1:0]        req_angle0,
  input  logic [A-1:0]        req_angle1,
  output logic [1:0]          req_ready,
  output logic                tab_en,
  output logic [A-3:0]        tab_addr,
  input  logic [N-2:0]        tab_data,
  output logic [1:0]          rsp_valid,
  output logic signed [N-1:0] rsp_sin,
  output logic signed [N-1:0] rsp_cos
);

  localparam int IW = A - 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SIN  = 2'd1,
    S_COS  = 2'd2,
    S_CAP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic                r_ptr;        // last granted port
  logic                r_owner;      // port owning the operation in flight
  logic [A-1:0]        r_angle;      // captured angle of the operation
  logic [N-2:0]        r_sin_mag;    // sin magnitude read during COS
  logic                r_tab_en;
  logic [IW-1:0]       r_tab_addr;
  logic [1:0]          r_rsp_valid;
  logic signed [N-1:0] r_rsp_sin;
  logic signed [N-1:0] r_rsp_cos;

  logic                w_grant_any;
  logic                w_grant_port;
  logic [A-1:0]        w_grant_angle;
  logic                w_hit;

  // ---------------------------------------------------------------------------
  // Quadrant folding helpers
  // ---------------------------------------------------------------------------
  // Odd quadrants walk the table backwards for sin; cos is the mirror image.
  function automatic logic [IW-1:0] sin_index(input logic [A-1:0] ang);
    logic [IW-1:0] i;
    i = ang[IW-1:0];
    return ang[A-2] ? ~i : i;
  endfunction

  function automatic logic [IW-1:0] cos_index(input logic [A-1:0] ang);
    logic [IW-1:0] i;
    i = ang[IW-1:0];
    return ang[A-2] ? i : ~i;
  endfunction

  // sin is negative in quadrants 2 and 3.
  function automatic logic sin_negative(input logic [A-1:0] ang);
    return ang[A-1];
  endfunction

  // cos is negative in quadrants 1 and 2.
  function automatic logic cos_negative(input logic [A-1:0] ang);
    return ang[A-1] ^ ang[A-2];
  endfunction

  // The magnitude is at most 2^(N-1)-1, so negation cannot overflow.
  function automatic logic [N-1:0] apply_sign(input logic [N-2:0] mag,
                                              input logic         neg);
    logic [N-1:0] v;
    v = {1'b0, mag};
    return neg ? (~v + {{(N-1){1'b0}}, 1'b1}) : v;
  endfunction

  // ---------------------------------------------------------------------------
  // Round-robin arbitration (only acted upon in IDLE)
  // ---------------------------------------------------------------------------
  // With both ports valid, the port that did not win last time goes next.
  assign w_grant_any   = |req_valid;
  assign w_grant_port  = (&req_valid) ? ~r_ptr : req_valid[1];
  assign w_grant_angle = w_grant_port ? req_angle1 : req_angle0;

`ifdef SINCOS_CACHE_EN
  logic [A-1:0] r_cache_angle;
  logic         r_cache_valid;

  // A hit is answered from the held rsp_sin/rsp_cos, so no table reads
  // are needed.
  assign w_hit = r_cache_valid && (w_grant_angle == r_cache_angle);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cache_angle <= '0;
      r_cache_valid <= 1'b0;
    end else if (r_state == S_CAP) begin
      r_cache_angle <= r_angle;
      r_cache_valid <= 1'b1;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_any && !w_hit) w_state_next = S_SIN;
      S_SIN:   w_state_next = S_COS;
      S_COS:   w_state_next = S_CAP;
      S_CAP:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: combinational outputs
  // ---------------------------------------------------------------------------
  // The accept pulse goes out in the grant cycle itself, and only to the
  // winner.
  always_comb begin
    req_ready = 2'b00;
    if ((r_state == S_IDLE) && w_grant_any) begin
      req_ready = w_grant_port ? 2'b10 : 2'b01;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath / registered outputs
  // ---------------------------------------------------------------------------
  // Table reads are issued from registers, so the sin address must be loaded
  // in the grant cycle. That puts it on tab_addr during SIN. The read data
  // then arrives one state later: the sin magnitude during COS and the cos
  // magnitude during CAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= 1'b1;
      r_owner     <= 1'b0;
      r_angle     <= '0;
      r_sin_mag   <= '0;
      r_tab_en    <= 1'b0;
      r_tab_addr  <= '0;
      r_rsp_valid <= 2'b00;
      r_rsp_sin   <= '0;
      r_rsp_cos   <= '0;
    end else begin
      r_rsp_valid <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_ptr   <= w_grant_port;
            r_owner <= w_grant_port;
            if (w_hit) begin
              r_rsp_valid <= w_grant_port ? 2'b10 : 2'b01;
            end else begin
              r_angle    <= w_grant_angle;
              r_tab_en   <= 1'b1;
              r_tab_addr <= sin_index(w_grant_angle);
            end
          end
        end
        S_SIN: begin
          r_tab_addr <= cos_index(r_angle);
        end
        S_COS: begin
          r_tab_en  <= 1'b0;
          r_sin_mag <= tab_data;
        end
        S_CAP: begin
          r_rsp_sin   <= apply_sign(r_sin_mag, sin_negative(r_angle));
          r_rsp_cos   <= apply_sign(tab_data, cos_negative(r_angle));
          r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
        end
        default: begin
          r_tab_en <= 1'b0;
        end
      endcase
    end
  end

  assign tab_en    = r_tab_en;
  assign tab_addr  = r_tab_addr;
  assign rsp_valid = r_rsp_valid;
  assign rsp_sin   = r_rsp_sin;
  assign rsp_cos   = r_rsp_cos;

endmodule

// File: tb/tb_sincos_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sincos_arbiter
//
// Scoreboard bench for sincos_arbiter (N=16, A=6).
// - The driver issues directed requests. On each observed grant it pushes the
//   expected table addresses and the expected response, taken from a
//   hand-computed vector table.
// - A separate monitor checks every table read and every response against
//   those queues, including the response cycle.
// The table model returns T[k] = 2001*k + 100, one cycle after tab_en.
// -----------------------------------------------------------------------------
module tb_sincos_arbiter;

  localparam int N = 16;
  localparam int A = 6;

`ifdef SINCOS_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         req_valid;
  logic [A-1:0]       req_angle0;
  logic [A-1:0]       req_angle1;
  logic [1:0]         req_ready;
  logic               tab_en;
  logic [A-3:0]       tab_addr;
  logic [N-2:0]       tab_data = '0;
  logic [1:0]         rsp_valid;
  logic signed [N-1:0] rsp_sin;
  logic signed [N-1:0] rsp_cos;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          port;
    logic [15:0] s;
    logic [15:0] c;
    int          due;
  } rsp_t;

  rsp_t rsp_q[$];
  int   addr_q[$];

  sincos_arbiter #(.N(N), .A(A)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_angle0 (req_angle0),
    .req_angle1 (req_angle1),
    .req_ready  (req_ready),
    .tab_en     (tab_en),
    .tab_addr   (tab_addr),
    .tab_data   (tab_data),
    .rsp_valid  (rsp_valid),
    .rsp_sin    (rsp_sin),
    .rsp_cos    (rsp_cos)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [14:0] tval(input logic [3:0] k);
    return 15'(2001 * int'(k) + 100);
  endfunction

  // Table model with a one-cycle registered read.
  always @(posedge clk) if (tab_en) tab_data <= tval(tab_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Hand-folded vectors: sin index/sign and cos index/sign for each angle used.
  task automatic lookup(input int angle, output int sidx, output bit sneg,
                        output int cidx, output bit cneg);
    case (angle)
      0:       begin sidx = 0;  sneg = 0; cidx = 15; cneg = 0; end
      40:      begin sidx = 8;  sneg = 1; cidx = 7;  cneg = 1; end
      63:      begin sidx = 0;  sneg = 1; cidx = 15; cneg = 0; end
      5:       begin sidx = 5;  sneg = 0; cidx = 10; cneg = 0; end
      20:      begin sidx = 11; sneg = 0; cidx = 4;  cneg = 1; end
      17:      begin sidx = 14; sneg = 0; cidx = 1;  cneg = 1; end
      default: begin sidx = 0;  sneg = 0; cidx = 0;  cneg = 0; end
    endcase
  endtask

  function automatic logic [15:0] signed_val(input logic [14:0] m, input bit neg);
    logic [15:0] v;
    v = {1'b0, m};
    return neg ? 16'(-v) : v;
  endfunction

  task automatic push_exp(input int port, input int angle, input int gcyc, input bit hit);
    int sidx, cidx;
    bit sneg, cneg;
    rsp_t e;
    lookup(angle, sidx, sneg, cidx, cneg);
    e.port = port;
    e.s    = signed_val(tval(4'(sidx)), sneg);
    e.c    = signed_val(tval(4'(cidx)), cneg);
    e.due  = gcyc + (hit ? 1 : 4);
    if (!hit) begin
      addr_q.push_back(sidx);
      addr_q.push_back(cidx);
    end
    rsp_q.push_back(e);
  endtask

  // Monitor: every table read and every response must have been expected.
  always @(negedge clk) begin
    rsp_t e;
    int   a;
    if (tab_en === 1'b1) begin
      if (addr_q.size() == 0) begin
        chk("unexpected_tab_read", {28'd0, tab_addr}, 32'hFFFF_FFFF);
      end else begin
        a = addr_q.pop_front();
        chk("tab_addr", {28'd0, tab_addr}, a);
      end
    end
    if ((rsp_valid !== 2'b00) && (rsp_valid !== 2'bxx)) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected_rsp", {30'd0, rsp_valid}, 0);
      end else begin
        e = rsp_q.pop_front();
        chk("rsp_valid", {30'd0, rsp_valid}, (e.port == 1) ? 2 : 1);
        chk("rsp_sin", {16'd0, rsp_sin}, {16'd0, e.s});
        chk("rsp_cos", {16'd0, rsp_cos}, {16'd0, e.c});
        chk("rsp_cycle", cyc, e.due);
      end
    end
  end

  task automatic wait_grant(input logic [1:0] exp_ready, output int gcyc);
    bit got;
    got = 0;
    gcyc = cyc;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("grant_timeout", 1, 0);
    else      chk("grant_port", {30'd0, req_ready}, {30'd0, exp_ready});
    gcyc = cyc;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      if (rsp_q.size() == 0 && addr_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      chk("rsp_timeout", rsp_q.size(), 0);
      rsp_q.delete();
      addr_q.delete();
    end
  endtask

  task automatic single(input int port, input int angle, input bit hit);
    int g;
    @(posedge clk); #1;
    if (port == 0) req_angle0 = 6'(angle); else req_angle1 = 6'(angle);
    req_valid = (port == 0) ? 2'b01 : 2'b10;
    wait_grant(req_valid, g);
    push_exp(port, angle, g, hit);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_rsp_valid"}, {30'd0, rsp_valid}, 0);
    chk({tag, "_rsp_sin"},   {16'd0, rsp_sin}, 0);
    chk({tag, "_rsp_cos"},   {16'd0, rsp_cos}, 0);
    chk({tag, "_tab_en"},    {31'd0, tab_en}, 0);
    chk({tag, "_tab_addr"},  {28'd0, tab_addr}, 0);
  endtask

  initial begin
    int g, prev;
    rst        = 1'b1;
    req_valid  = 2'b00;
    req_angle0 = '0;
    req_angle1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("reset");
    chk("reset_req_ready", {30'd0, req_ready}, 0);

    // Basic single-port operations.
    single(0, 0, 1'b0);
    single(1, 40, 1'b0);

    // Both ports valid: grants alternate 0,1,0,1, four cycles apart.
    @(posedge clk); #1;
    req_angle0 = 6'd5;
    req_angle1 = 6'd20;
    req_valid  = 2'b11;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant((k % 2 == 0) ? 2'b01 : 2'b10, g);
      if (k > 0) chk("grant_spacing", g - prev, 4);
      push_exp(k % 2, (k % 2 == 0) ? 5 : 20, g, 1'b0);
      prev = g;
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();

    single(0, 63, 1'b0);

    // Reset at G+2 aborts the operation; the pointer then favours port 0 again.
    @(posedge clk); #1;
    req_angle0 = 6'd63;
    req_valid  = 2'b01;
    wait_grant(2'b01, g);
    push_exp(0, 63, g, 1'b0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_q.delete();
    addr_q.delete();
    @(negedge clk);
    check_zero_outputs("midop_reset");
    repeat (5) @(posedge clk);
    #1;
    req_angle0 = 6'd0;
    req_angle1 = 6'd40;
    req_valid  = 2'b11;
    wait_grant(2'b01, g);
    push_exp(0, 0, g, 1'b0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();

    // Repeated angle: a one-cycle hit with the cache, a full sequence without it.
    single(1, 17, 1'b0);
    single(1, 17, CACHE);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
